// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types, timebase helpers and playfield constants
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  // Playfield limits used by the player position stage.
  localparam int PLAYFIELD_LEFT  = 265;
  localparam int PLAYFIELD_RIGHT = 613;

  // Clock cycles per timebase period.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Counter width able to hold 0..div-1.
  function automatic int calc_div_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - key synchronizer and tick-based debounce FSM (BTN_DEBOUNCE_BYPASS_EN skips the FSM)
module btn_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic db
);

  localparam logic       RELEASED_LVL = ACTIVE_LOW;
  localparam logic [7:0] LAST_TICK    = 8'(DEBOUNCE_MS - 1);

  logic [1:0] sync_q, sync_d;
  logic       pressed;

  // Two-flop synchronizer; resets to the released level so no phantom press.
  always_comb begin
    sync_d = {sync_q[0], raw};
  end

  // Synchronizer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {2{RELEASED_LVL}};
    else     sync_q <= sync_d;
  end

  assign pressed = sync_q[1] ^ ACTIVE_LOW;

`ifdef BTN_DEBOUNCE_BYPASS_EN
  logic unused_tick;
  assign unused_tick = tick;
  assign db          = pressed;
`else
  btn_state_t state_q, state_d;
  logic [7:0] stab_cnt_q, stab_cnt_d;

  // Next state: a level must hold for DEBOUNCE_MS ticks before it is accepted.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d    = PRESS_WAIT;
          stab_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (tick) begin
          if (stab_cnt_q == LAST_TICK) state_d = PRESSED;
          else stab_cnt_d = stab_cnt_q + 8'd1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d    = RELEASE_WAIT;
          stab_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = PRESSED;
        end else if (tick) begin
          if (stab_cnt_q == LAST_TICK) state_d = IDLE;
          else stab_cnt_d = stab_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and stability counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      stab_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  assign db = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
`endif

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - 1 ms timebase, two debounced keys and left/right arbitration (BTN_DEBOUNCE_BYPASS_EN)
module button_conditioner
  import game_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int DEBOUNCE_MS = 10,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_left,
  input  logic key_right,
  output logic clk_1ms,
  output logic tick_1ms,
  output logic button,
  output logic button1
);

  localparam int            DIV      = calc_div(CLK_HZ, TICK_HZ);
  localparam int            CW       = calc_div_width(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          tick_q, tick_d;
  logic          clk_1ms_q, clk_1ms_d;
  logic          button_q, button_d;
  logic          button1_q, button1_d;
  logic          db_left, db_right;

  // Divider: registered tick lands on div_cnt==DIV-1, clk_1ms high for div_cnt 0..DIV/2-1.
  always_comb begin
    div_cnt_d = (div_cnt_q == CNT_LAST) ? '0 : div_cnt_q + 1'b1;
    tick_d    = (div_cnt_q == CNT_PRE);
    clk_1ms_d = clk_1ms_q;
    if (div_cnt_q == CNT_LAST)      clk_1ms_d = 1'b1;
    else if (div_cnt_q == CNT_HALF) clk_1ms_d = 1'b0;
  end

  // Divider registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      clk_1ms_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      clk_1ms_q <= clk_1ms_d;
    end
  end

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .ACTIVE_LOW(ACTIVE_LOW)) u_left (
    .clk (clk),
    .rst (rst),
    .tick(tick_q),
    .raw (key_left),
    .db  (db_left)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .ACTIVE_LOW(ACTIVE_LOW)) u_right (
    .clk (clk),
    .rst (rst),
    .tick(tick_q),
    .raw (key_right),
    .db  (db_right)
  );

  // Arbitration: both keys held means no movement.
  always_comb begin
    button_d  = db_left & ~db_right;
    button1_d = db_right & ~db_left;
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      button_q  <= 1'b0;
      button1_q <= 1'b0;
    end else begin
      button_q  <= button_d;
      button1_q <= button1_d;
    end
  end

  assign clk_1ms  = clk_1ms_q;
  assign tick_1ms = tick_q;
  assign button   = button_q;
  assign button1  = button1_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner (DIV=10, DEBOUNCE_MS=3; BTN_DEBOUNCE_BYPASS_EN)
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_left = 1'b1;
  logic key_right = 1'b1;
  logic clk_1ms, tick_1ms, button, button1;

  button_conditioner #(
    .CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_MS(3), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .key_left(key_left), .key_right(key_right),
    .clk_1ms(clk_1ms), .tick_1ms(tick_1ms), .button(button), .button1(button1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    logic  b;
    logic  b1;
    string tag;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int base = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider checked every cycle from the edge count since reset release; buttons from the scoreboard.
  always @(negedge clk) begin
    int   k;
    logic exp_tick, exp_clk;
    exp_t e;
    k        = cyc - base;
    exp_tick = !rst && (k % 10 == 9);
    exp_clk  = !rst && (k >= 10) && (k % 10 < 5);
    checks++;
    assert (tick_1ms === exp_tick) else begin
      errors++;
      $error("FAIL tick_1ms cyc=%0d observed=%b expected=%b", cyc, tick_1ms, exp_tick);
    end
    checks++;
    assert (clk_1ms === exp_clk) else begin
      errors++;
      $error("FAIL clk_1ms cyc=%0d observed=%b expected=%b", cyc, clk_1ms, exp_clk);
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      assert (e.cyc == cyc && button === e.b && button1 === e.b1) else begin
        errors++;
        $error("FAIL %s cyc=%0d/%0d observed=%b%b expected=%b%b",
               e.tag, cyc, e.cyc, button, button1, e.b, e.b1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic expect_range(input int from, input int to, input logic b, input logic b1,
                              input string tag);
    exp_t e;
    for (int i = from; i <= to; i++) begin
      e.cyc = i; e.b = b; e.b1 = b1; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  // Edge at which the output register changes for a key level applied after edge c:
  // 2 sync flops + 1 FSM entry, then n ticks counted, then the state and output registers.
  function automatic int qual_edge(input int c, input int n);
    int j, cnt;
    j = c + 3;
    cnt = 0;
    while (1) begin
      if ((j - base) % 10 == 9) begin
        cnt++;
        if (cnt == n) return j + 2;
      end
      j++;
    end
  endfunction

  initial begin
    int c, c2, r, f, q;

    step(3);
    rst = 1'b0;
    base = cyc;

    // Idle after reset: no movement, divider running.
    expect_range(cyc + 1, cyc + 30, 1'b0, 1'b0, "reset_idle");
    step(30);

`ifdef BTN_DEBOUNCE_BYPASS_EN
    // One-clock key pulse appears on button exactly three clocks later.
    c = cyc;
    expect_range(c + 1, c + 2, 1'b0, 1'b0, "bypass_pre");
    expect_range(c + 3, c + 3, 1'b1, 1'b0, "bypass_pulse");
    expect_range(c + 4, c + 6, 1'b0, 1'b0, "bypass_post");
    key_left = 1'b0;
    step(1);
    key_left = 1'b1;
    step(6);
`else
    // Bounce: 5-clock presses never last 3 ticks.
    c = cyc;
    expect_range(c + 1, c + 60, 1'b0, 1'b0, "bounce");
    for (int i = 0; i < 4; i++) begin
      key_left = 1'b0;
      step(5);
      key_left = 1'b1;
      step(5);
    end
    step(20);

    // Held left key qualifies and later releases on tick boundaries.
    c = cyc;
    r = qual_edge(c, 3);
    f = qual_edge(c + 40, 3);
    expect_range(c + 1, r - 1, 1'b0, 1'b0, "left_wait");
    expect_range(r, f - 1, 1'b1, 1'b0, "left_held");
    expect_range(f, f + 5, 1'b0, 1'b0, "left_released");
    key_left = 1'b0;
    step(40);
    key_left = 1'b1;
    step(f + 6 - cyc);

    // Both held: no movement; releasing right lets left through.
    c = cyc;
    expect_range(c + 1, c + 60, 1'b0, 1'b0, "both_held");
    key_left = 1'b0;
    key_right = 1'b0;
    step(60);
    key_right = 1'b1;
    c2 = cyc;
    r = qual_edge(c2, 3);
    expect_range(c2 + 1, r - 1, 1'b0, 1'b0, "right_release_wait");
    expect_range(r, r + 5, 1'b1, 1'b0, "left_alone");
    step(r + 5 - cyc);
    key_left = 1'b1;
    c2 = cyc;
    f = qual_edge(c2, 3);
    expect_range(c2 + 1, f - 1, 1'b1, 1'b0, "left_release_wait");
    expect_range(f, f + 3, 1'b0, 1'b0, "all_released");
    step(f + 3 - cyc);

    // Reset mid-press clears button1 at once and forces full requalification.
    key_right = 1'b0;
    c = cyc;
    q = qual_edge(c, 3);
    expect_range(c + 1, q - 1, 1'b0, 1'b0, "right_wait");
    expect_range(q, q + 4, 1'b0, 1'b1, "right_held");
    step(q + 4 - cyc);
    rst = 1'b1;
    #1;
    checks++;
    assert (button1 === 1'b0 && button === 1'b0) else begin
      errors++;
      $error("FAIL rst_async observed=%b%b expected=00", button, button1);
    end
    step(2);
    rst = 1'b0;
    base = cyc;
    q = qual_edge(cyc, 3);
    expect_range(cyc + 1, q - 1, 1'b0, 1'b0, "requal_wait");
    expect_range(q, q + 3, 1'b0, 1'b1, "requal_held");
    step(q + 3 - cyc);
    key_right = 1'b1;
    step(5);
`endif

    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
